// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through dcache, including the SHiP
// dead-block predictor's signature width, FSM states and index hash.
package wt_cache_pkg;

    localparam int unsigned SHIP_SIG_WIDTH = 14;

    typedef enum logic {
        SHIP_INIT,
        SHIP_RUN
    } ship_state_e;

    // XOR-fold the signature into idx_w-bit chunks; the top chunk is zero-padded.
    function automatic logic [SHIP_SIG_WIDTH-1:0] ship_hash(
        input logic [SHIP_SIG_WIDTH-1:0] sig,
        input int unsigned               idx_w
    );
        logic [SHIP_SIG_WIDTH-1:0] mask;
        logic [SHIP_SIG_WIDTH-1:0] h;
        h = '0;
        if (idx_w == 0) return h;
        mask = (idx_w >= SHIP_SIG_WIDTH) ? '1 : SHIP_SIG_WIDTH'((1 << idx_w) - 1);
        for (int unsigned c = 0; c < SHIP_SIG_WIDTH; c += idx_w) begin
            h ^= (sig >> c) & mask;
        end
        return h;
    endfunction

endpackage

// File: rtl/wt_dcache_ship_cnt.sv
// One SHCT entry: saturating up/down counter with an init-load that overrides training.
module wt_dcache_ship_cnt #(
    parameter int unsigned CntWidth = 3,
    parameter int unsigned CntInit  = 1
) (
    input  logic                clk_i,
    input  logic                load_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] cnt_q;

    // Counter contents are rebuilt by the init sweep, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            cnt_q <= CntWidth'(CntInit);
        end else if (inc_i && !dec_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/wt_dcache_ship_pred.sv
// SHiP-style dead-block predictor (signature hit counter table) for the WT dcache.
// Optional lookup statistics are enabled with `define WT_DCACHE_SHIP_STATS_EN.
module wt_dcache_ship_pred
    import wt_cache_pkg::*;
#(
    parameter int unsigned IdxWidth = 8,
    parameter int unsigned CntWidth = 3,
    parameter int unsigned CntInit  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      ready_o,
    input  logic                      lkp_vld_i,
    input  logic [SHIP_SIG_WIDTH-1:0] lkp_signature_i,
    output logic                      pred_vld_o,
    output logic                      pred_dead_o,
    output logic [CntWidth-1:0]       pred_cnt_o,
    input  logic                      hit_vld_i,
    input  logic [SHIP_SIG_WIDTH-1:0] hit_signature_i,
    input  logic                      hit_first_i,
    input  logic                      evict_vld_i,
    input  logic [SHIP_SIG_WIDTH-1:0] evict_signature_i,
    input  logic                      evict_ever_hit_i
`ifdef WT_DCACHE_SHIP_STATS_EN
    ,
    output logic [31:0]               stat_lkp_cnt_o,
    output logic [31:0]               stat_dead_cnt_o
`endif
);

    localparam int unsigned Entries = 2 ** IdxWidth;

    ship_state_e         state_q, state_d;
    logic [IdxWidth-1:0] sweep_idx_q;
    logic                run;

    logic [IdxWidth-1:0] lkp_idx_p0, hit_idx_p0, evict_idx_p0;
    logic                lkp_acc_p0, inc_vld_p0, dec_vld_p0;
    logic [CntWidth-1:0] cnt_q [Entries];
    logic [CntWidth-1:0] rd_cnt_p0;

    logic                pred_vld_p1, pred_dead_p1;
    logic [CntWidth-1:0] pred_cnt_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SHIP_INIT;
            sweep_idx_q <= '0;
            ready_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == SHIP_INIT) sweep_idx_q <= sweep_idx_q + 1'b1;
            ready_o <= (state_d == SHIP_RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == SHIP_INIT) && (sweep_idx_q == '1)) state_d = SHIP_RUN;
    end

    assign run = (state_q == SHIP_RUN);

    // p0: hash all three signatures and qualify events; nothing is accepted during the sweep.
    assign lkp_idx_p0   = IdxWidth'(ship_hash(lkp_signature_i, IdxWidth));
    assign hit_idx_p0   = IdxWidth'(ship_hash(hit_signature_i, IdxWidth));
    assign evict_idx_p0 = IdxWidth'(ship_hash(evict_signature_i, IdxWidth));
    assign lkp_acc_p0   = run && lkp_vld_i;
    assign inc_vld_p0   = run && hit_vld_i && hit_first_i;
    assign dec_vld_p0   = run && evict_vld_i && !evict_ever_hit_i;

    for (genvar g = 0; g < Entries; g++) begin : gen_shct
        wt_dcache_ship_cnt #(
            .CntWidth (CntWidth),
            .CntInit  (CntInit)
        ) u_cnt (
            .clk_i  (clk_i),
            .load_i (!run && (sweep_idx_q == IdxWidth'(g))),
            .inc_i  (inc_vld_p0 && (hit_idx_p0 == IdxWidth'(g))),
            .dec_i  (dec_vld_p0 && (evict_idx_p0 == IdxWidth'(g))),
            .cnt_o  (cnt_q[g])
        );
    end

    // Read sees the pre-update value: counter writes land on the same edge as this register.
    assign rd_cnt_p0 = cnt_q[lkp_idx_p0];

    // p1: registered prediction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_vld_p1  <= 1'b0;
            pred_dead_p1 <= 1'b0;
            pred_cnt_p1  <= '0;
        end else begin
            pred_vld_p1 <= lkp_acc_p0;
            if (lkp_acc_p0) begin
                pred_cnt_p1  <= rd_cnt_p0;
                pred_dead_p1 <= (rd_cnt_p0 == '0);
            end
        end
    end

    assign pred_vld_o  = pred_vld_p1;
    assign pred_dead_o = pred_dead_p1;
    assign pred_cnt_o  = pred_cnt_p1;

`ifdef WT_DCACHE_SHIP_STATS_EN
    logic [31:0] stat_lkp_q, stat_dead_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_lkp_q  <= '0;
            stat_dead_q <= '0;
        end else if (lkp_acc_p0) begin
            if (stat_lkp_q != '1) stat_lkp_q <= stat_lkp_q + 1'b1;
            if ((rd_cnt_p0 == '0) && (stat_dead_q != '1)) stat_dead_q <= stat_dead_q + 1'b1;
        end
    end

    assign stat_lkp_cnt_o  = stat_lkp_q;
    assign stat_dead_cnt_o = stat_dead_q;
`endif

endmodule
